// File: rtl/usb_device_line_tx_if.sv
// Byte-stream handshake between bench stimulus and the USB line transmitter.
interface usb_device_line_tx_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       in_last;

  modport master (output in_valid, output in_data, output in_last, input in_ready);
  modport slave  (input in_valid, input in_data, input in_last, output in_ready);
endinterface

// File: rtl/usb_device_line_tx.sv
// USB device-side line model: attach sequencing, host reset detect and
// packet transmit (SYNC, NRZI, bit stuffing, EOP) from a small byte FIFO.
module usb_device_line_tx #(
  parameter int unsigned SPEED       = 1,
  parameter int unsigned CLK_DIV     = 32,
  parameter int unsigned CON_TICKS   = 30,
  parameter int unsigned RESET_TICKS = 16,
  parameter int unsigned FIFO_DEPTH  = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       vbus,
  input  logic       dp_i,
  input  logic       dm_i,
  output logic       dp_o,
  output logic       dm_o,
  output logic       line_oe,
  output logic       pull_dp,
  output logic       pull_dm,
  output logic       tx_busy,
  output logic       bus_reset,
  output logic [2:0] state_o,
  usb_device_line_tx_if.slave tx_if
);

  localparam int unsigned DIV_W = $clog2(CLK_DIV);
  localparam int unsigned CON_W = $clog2(CON_TICKS + 1);
  localparam int unsigned SE0_W = $clog2(RESET_TICKS + 1);
  localparam int unsigned AW    = $clog2(FIFO_DEPTH);
  localparam int unsigned CW    = AW + 1;

  typedef enum logic [2:0] {
    ST_DISCON  = 3'd0,
    ST_CON     = 3'd1,
    ST_IDLE    = 3'd2,
    ST_TX_SYNC = 3'd3,
    ST_TX_DATA = 3'd4,
    ST_TX_EOP  = 3'd5
  } state_e;

  state_e           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [CON_W-1:0] con_q, con_d;
  logic [SE0_W-1:0] se0_q, se0_d;
  logic [2:0]       ones_q, ones_d;
  logic [2:0]       bit_q, bit_d;
  logic [1:0]       eop_q, eop_d;
  logic             lvl_q, lvl_d;    // 1 = J, 0 = K
  logic             done_q, done_d;  // last byte of the packet has been sent
  logic             dp_q, dp_d, dm_q, dm_d, oe_q, oe_d;
  logic             pdp_q, pdp_d, pdm_q, pdm_d;
  logic             busy_q, busy_d, brst_q, brst_d, rdy_q, rdy_d;
  logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]    cnt_q, cnt_d, pkt_q, pkt_d;
  logic [8:0]       mem [FIFO_DEPTH];

  logic [7:0] head_data_c;
  logic       head_last_c, bit_tick_c, se0_c, wr_c, pop_c, flush_c;

  // Map a J/K level onto the pad pair for the configured speed.
  function automatic logic [1:0] line_of(input logic lvl);
    return (SPEED != 0) ? {lvl, ~lvl} : {~lvl, lvl};
  endfunction

  assign head_data_c = mem[rd_q][7:0];
  assign head_last_c = mem[rd_q][8];
  assign bit_tick_c  = (state_q != ST_DISCON) && (div_q == DIV_W'(CLK_DIV - 1));
  assign se0_c       = !dp_i && !dm_i;
  assign wr_c        = tx_if.in_valid && rdy_q;

  // Next-state, line symbol and FIFO bookkeeping.
  always_comb begin
    state_d = state_q;  div_d = div_q;    con_d = con_q;    se0_d = '0;
    ones_d  = ones_q;   bit_d = bit_q;    eop_d = eop_q;    lvl_d = lvl_q;
    done_d  = done_q;   dp_d  = dp_q;     dm_d  = dm_q;     oe_d  = oe_q;
    pdp_d   = pdp_q;    pdm_d = pdm_q;    busy_d = busy_q;  brst_d = 1'b0;
    wr_d    = wr_q;     rd_d  = rd_q;     cnt_d = cnt_q;    pkt_d = pkt_q;
    rdy_d   = rdy_q;    pop_c = 1'b0;     flush_c = 1'b0;

    if (state_q == ST_DISCON || bit_tick_c) div_d = '0;
    else                                    div_d = div_q + DIV_W'(1);

    case (state_q)
      ST_DISCON: begin
        if (vbus) begin
          state_d = ST_CON;
          oe_d    = 1'b0;
          pdp_d   = (SPEED != 0);
          pdm_d   = (SPEED == 0);
          lvl_d   = 1'b1;
          {dp_d, dm_d} = line_of(1'b1);
          con_d   = '0;
        end
      end
      ST_CON: begin
        if (bit_tick_c) begin
          if (con_q == CON_W'(CON_TICKS - 1)) begin
            state_d = ST_IDLE;
            con_d   = '0;
          end else begin
            con_d = con_q + CON_W'(1);
          end
        end
      end
      ST_IDLE: begin
        // Host SE0 run length; saturates so one long reset gives one pulse.
        if (se0_c) begin
          se0_d = se0_q;
          if (bit_tick_c && se0_q != SE0_W'(RESET_TICKS)) begin
            se0_d = se0_q + SE0_W'(1);
            if (se0_q == SE0_W'(RESET_TICKS - 1)) begin
              brst_d  = 1'b1;
              flush_c = 1'b1;
            end
          end
        end
        if (bit_tick_c && pkt_q != '0 && !flush_c) begin
          state_d = ST_TX_SYNC;
          busy_d  = 1'b1;
          oe_d    = 1'b1;
          lvl_d   = ~lvl_q;
          {dp_d, dm_d} = line_of(~lvl_q);
          bit_d   = 3'd1;
          ones_d  = '0;
          done_d  = 1'b0;
        end
      end
      ST_TX_SYNC: begin
        if (bit_tick_c) begin
          if (bit_q == 3'd7) begin
            ones_d  = 3'd1;
            bit_d   = '0;
            state_d = ST_TX_DATA;
          end else begin
            lvl_d = ~lvl_q;
            {dp_d, dm_d} = line_of(~lvl_q);
            bit_d = bit_q + 3'd1;
          end
        end
      end
      ST_TX_DATA: begin
        if (bit_tick_c) begin
          if (ones_q == 3'd6) begin
            lvl_d  = ~lvl_q;
            {dp_d, dm_d} = line_of(~lvl_q);
            ones_d = '0;
          end else if (done_q) begin
            dp_d    = 1'b0;
            dm_d    = 1'b0;
            state_d = ST_TX_EOP;
            eop_d   = 2'd1;
          end else begin
            if (head_data_c[bit_q]) begin
              ones_d = ones_q + 3'd1;
            end else begin
              lvl_d  = ~lvl_q;
              {dp_d, dm_d} = line_of(~lvl_q);
              ones_d = '0;
            end
            if (bit_q == 3'd7) begin
              pop_c  = 1'b1;
              bit_d  = '0;
              done_d = head_last_c;
            end else begin
              bit_d = bit_q + 3'd1;
            end
          end
        end
      end
      ST_TX_EOP: begin
        if (bit_tick_c) begin
          case (eop_q)
            2'd1: eop_d = 2'd2;
            2'd2: begin
              lvl_d = 1'b1;
              {dp_d, dm_d} = line_of(1'b1);
              eop_d = 2'd3;
            end
            default: begin
              state_d = ST_IDLE;
              oe_d    = 1'b0;
              busy_d  = 1'b0;
              done_d  = 1'b0;
              eop_d   = '0;
              ones_d  = '0;
            end
          endcase
        end
      end
      default: state_d = ST_DISCON;
    endcase

    // Loss of bus power wins over everything, aborting any packet silently.
    if (!vbus) begin
      state_d = ST_DISCON; div_d = '0;  con_d = '0;  se0_d = '0;
      ones_d  = '0;        bit_d = '0;  eop_d = '0;  lvl_d = 1'b1;
      done_d  = 1'b0;      dp_d  = 1'b0; dm_d = 1'b0; oe_d = 1'b1;
      pdp_d   = 1'b0;      pdm_d = 1'b0; busy_d = 1'b0; brst_d = 1'b0;
      flush_c = 1'b1;
    end

    if (flush_c) begin
      wr_d = '0; rd_d = '0; cnt_d = '0; pkt_d = '0;
    end else begin
      if (wr_c)  wr_d = wr_q + AW'(1);
      if (pop_c) rd_d = rd_q + AW'(1);
      cnt_d = cnt_q + CW'(wr_c) - CW'(pop_c);
      pkt_d = pkt_q + CW'(wr_c && tx_if.in_last) - CW'(pop_c && head_last_c);
    end

    rdy_d = (cnt_d != CW'(FIFO_DEPTH)) && (state_d != ST_DISCON);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_DISCON; div_q <= '0;  con_q <= '0;  se0_q <= '0;
      ones_q  <= '0;        bit_q <= '0;  eop_q <= '0;  lvl_q <= 1'b1;
      done_q  <= 1'b0;      dp_q  <= 1'b0; dm_q <= 1'b0; oe_q <= 1'b1;
      pdp_q   <= 1'b0;      pdm_q <= 1'b0; busy_q <= 1'b0; brst_q <= 1'b0;
      rdy_q   <= 1'b0;      wr_q  <= '0;  rd_q <= '0;   cnt_q <= '0;
      pkt_q   <= '0;
    end else begin
      state_q <= state_d; div_q <= div_d; con_q <= con_d; se0_q <= se0_d;
      ones_q  <= ones_d;  bit_q <= bit_d; eop_q <= eop_d; lvl_q <= lvl_d;
      done_q  <= done_d;  dp_q  <= dp_d;  dm_q  <= dm_d;  oe_q  <= oe_d;
      pdp_q   <= pdp_d;   pdm_q <= pdm_d; busy_q <= busy_d; brst_q <= brst_d;
      rdy_q   <= rdy_d;   wr_q  <= wr_d;  rd_q  <= rd_d;  cnt_q <= cnt_d;
      pkt_q   <= pkt_d;
    end
  end

  // FIFO storage: {last, data}.
  always_ff @(posedge clk) begin
    if (wr_c) mem[wr_q] <= {tx_if.in_last, tx_if.in_data};
  end

  assign dp_o           = dp_q;
  assign dm_o           = dm_q;
  assign line_oe        = oe_q;
  assign pull_dp        = pdp_q;
  assign pull_dm        = pdm_q;
  assign tx_busy        = busy_q;
  assign bus_reset      = brst_q;
  assign state_o        = state_q;
  assign tx_if.in_ready = rdy_q;

endmodule

// File: tb/tb_usb_device_line_tx.sv
// Scoreboard bench: a full-speed DUT (main) and a low-speed DUT (directed).
module tb_usb_device_line_tx;
  localparam int DIV_FS = 32;
  localparam int DIV_LS = 4;
  localparam int S_SE0 = 0, S_J = 1, S_K = 2, S_Z = 3, S_X = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, vbus_fs, vbus_ls, host_se0;
  logic fs_dp_o, fs_dm_o, fs_oe, fs_pdp, fs_pdm, fs_busy, fs_brst, fs_dp_i, fs_dm_i;
  logic ls_dp_o, ls_dm_o, ls_oe, ls_pdp, ls_pdm, ls_busy, ls_brst, ls_dp_i, ls_dm_i;
  logic [2:0] fs_state, ls_state;

  usb_device_line_tx_if fs_if ();
  usb_device_line_tx_if ls_if ();

  usb_device_line_tx #(.SPEED(1), .CLK_DIV(DIV_FS)) u_fs (
    .clk(clk), .reset(reset), .vbus(vbus_fs), .dp_i(fs_dp_i), .dm_i(fs_dm_i),
    .dp_o(fs_dp_o), .dm_o(fs_dm_o), .line_oe(fs_oe), .pull_dp(fs_pdp), .pull_dm(fs_pdm),
    .tx_busy(fs_busy), .bus_reset(fs_brst), .state_o(fs_state), .tx_if(fs_if));

  usb_device_line_tx #(.SPEED(0), .CLK_DIV(DIV_LS)) u_ls (
    .clk(clk), .reset(reset), .vbus(vbus_ls), .dp_i(ls_dp_i), .dm_i(ls_dm_i),
    .dp_o(ls_dp_o), .dm_o(ls_dm_o), .line_oe(ls_oe), .pull_dp(ls_pdp), .pull_dm(ls_pdm),
    .tx_busy(ls_busy), .bus_reset(ls_brst), .state_o(ls_state), .tx_if(ls_if));

  // Pads: released lines float to the pulled-up J level; host may force SE0.
  assign fs_dp_i = host_se0 ? 1'b0 : (fs_oe ? fs_dp_o : 1'b1);
  assign fs_dm_i = host_se0 ? 1'b0 : (fs_oe ? fs_dm_o : 1'b0);
  assign ls_dp_i = ls_oe ? ls_dp_o : 1'b0;
  assign ls_dm_i = ls_oe ? ls_dm_o : 1'b1;

  int n_pass = 0, n_chk = 0, brst_cnt = 0;
  int exp0[$], exp1[$], len0[$], len1[$];
  bit mon_off0 = 1'b0;

  always @(negedge clk) if (fs_brst) brst_cnt++;

  function automatic void check(string name, int act, int expv);
    n_chk++;
    if (act == expv) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, expv);
  endfunction

  function automatic int sym(int idx);
    logic oe, dp, dm, spd;
    if (idx == 0) begin oe = fs_oe; dp = fs_dp_o; dm = fs_dm_o; spd = 1'b1; end
    else          begin oe = ls_oe; dp = ls_dp_o; dm = ls_dm_o; spd = 1'b0; end
    if (!oe) return S_Z;
    if (!dp && !dm) return S_SE0;
    if (dp != dm) return (dp == spd) ? S_J : S_K;
    return S_X;
  endfunction

  function automatic logic busy(int idx);
    return (idx == 0) ? fs_busy : ls_busy;
  endfunction

  function automatic int pending(int idx);
    return (idx == 0) ? (len0.size() + exp0.size()) : (len1.size() + exp1.size());
  endfunction

  function automatic int pop_len(int idx);
    return (idx == 0) ? len0.pop_front() : len1.pop_front();
  endfunction

  function automatic int pop_sym(int idx);
    if (idx == 0) return (exp0.size() != 0) ? exp0.pop_front() : S_X;
    return (exp1.size() != 0) ? exp1.pop_front() : S_X;
  endfunction

  // Reference: bit list (SYNC + stuffed data) -> NRZI symbols -> EOP.
  task automatic model_pkt(int idx, input byte unsigned d[$]);
    int bits[$];
    int syms[$];
    int run, lvl;
    byte unsigned v;
    for (int i = 0; i < 7; i++) bits.push_back(0);
    bits.push_back(1);
    run = 1;
    foreach (d[i]) begin
      v = d[i];
      for (int b = 0; b < 8; b++) begin
        bits.push_back(int'(v[b]));
        run = v[b] ? run + 1 : 0;
        if (run == 6) begin bits.push_back(0); run = 0; end
      end
    end
    lvl = S_J;
    foreach (bits[k]) begin
      if (bits[k] == 0) lvl = (lvl == S_J) ? S_K : S_J;
      syms.push_back(lvl);
    end
    syms.push_back(S_SE0); syms.push_back(S_SE0); syms.push_back(S_J);
    foreach (syms[k]) if (idx == 0) exp0.push_back(syms[k]); else exp1.push_back(syms[k]);
    if (idx == 0) len0.push_back(syms.size()); else len1.push_back(syms.size());
  endtask

  // Monitor: on each tx_busy rise, sample one symbol per bit time.
  task automatic mon(int idx, int div);
    logic prev = 1'b0, b;
    int n, e, s;
    forever begin
      @(negedge clk);
      b = busy(idx);
      if (b && !prev && !(idx == 0 && mon_off0)) begin
        if (((idx == 0) ? len0.size() : len1.size()) == 0) begin
          check($sformatf("unexpected_tx%0d", idx), 1, 0);
        end else begin
          n = pop_len(idx);
          for (int k = 0; k < n; k++) begin
            if (k > 0) repeat (div) @(negedge clk);
            e = pop_sym(idx);
            s = sym(idx);
            check($sformatf("sym%0d_%0d", idx, k), s, e);
          end
          repeat (div) @(negedge clk);
          check($sformatf("busy_end%0d", idx), int'(busy(idx)), 0);
          check($sformatf("release_end%0d", idx), sym(idx), S_Z);
          b = busy(idx);
        end
      end
      prev = b;
    end
  endtask

  task automatic drive(int idx, logic v, byte unsigned d, logic l);
    if (idx == 0) begin fs_if.in_valid = v; fs_if.in_data = d; fs_if.in_last = l; end
    else          begin ls_if.in_valid = v; ls_if.in_data = d; ls_if.in_last = l; end
  endtask

  task automatic send_pkt(int idx, input byte unsigned d[$], input bit has_last);
    int t;
    @(negedge clk);
    foreach (d[i]) begin
      drive(idx, 1'b1, d[i], has_last && (i == d.size() - 1));
      t = 0;
      while (((idx == 0) ? fs_if.in_ready : ls_if.in_ready) !== 1'b1 && t < 20000) begin
        @(negedge clk);
        t++;
      end
      check("ready_timeout", int'(t < 20000), 1);
      @(negedge clk);
    end
    drive(idx, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic wait_done(int idx, int limit);
    int t = 0;
    while ((pending(idx) != 0 || busy(idx)) && t < limit) begin
      @(negedge clk);
      t++;
    end
    check($sformatf("drain_timeout%0d", idx), int'(t < limit), 1);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    byte unsigned pkt[$];
    int base, t, ok;
    reset = 1'b1; vbus_fs = 1'b0; vbus_ls = 1'b0; host_se0 = 1'b0;
    drive(0, 1'b0, 8'h00, 1'b0);
    drive(1, 1'b0, 8'h00, 1'b0);
    fork
      mon(0, DIV_FS);
      mon(1, DIV_LS);
    join_none

    // Reset values
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_state", int'(fs_state), 0);
    check("rst_oe", int'(fs_oe), 1);
    check("rst_line", int'({fs_dp_o, fs_dm_o}), 0);
    check("rst_pulls", int'({fs_pdp, fs_pdm}), 0);
    check("rst_ready", int'(fs_if.in_ready), 0);
    check("rst_busy_brst", int'({fs_busy, fs_brst}), 0);

    // Attach: CON on next clk, IDLE after exactly CON_TICKS bit times
    vbus_fs = 1'b1; vbus_ls = 1'b1;
    @(negedge clk);
    check("con_state", int'(fs_state), 1);
    check("con_pull_dp", int'(fs_pdp), 1);
    check("con_pull_dm", int'(fs_pdm), 0);
    check("con_oe", int'(fs_oe), 0);
    check("con_ready", int'(fs_if.in_ready), 1);
    check("ls_pulls", int'({ls_pdp, ls_pdm}), 1);
    repeat (30 * DIV_FS - 1) @(negedge clk);
    check("con_hold", int'(fs_state), 1);
    @(negedge clk);
    check("idle_state", int'(fs_state), 2);
    check("idle_oe", int'(fs_oe), 0);
    check("ls_idle_state", int'(ls_state), 2);
    check("ls_idle_j", int'({ls_dp_o, ls_dm_o, ls_oe}), 3'b010);

    // Low speed, byte 0x00
    pkt = {}; pkt.push_back(8'h00);
    model_pkt(1, pkt); send_pkt(1, pkt, 1'b1); wait_done(1, 2000);

    // Full speed directed: 0xA5, 0xFF
    pkt = {}; pkt.push_back(8'hA5);
    model_pkt(0, pkt); send_pkt(0, pkt, 1'b1); wait_done(0, 5000);
    pkt = {}; pkt.push_back(8'hFF);
    model_pkt(0, pkt); send_pkt(0, pkt, 1'b1); wait_done(0, 5000);

    // Randomised packets, queued back to back
    for (int p = 0; p < 10; p++) begin
      pkt = {};
      for (int i = 0; i < int'($urandom_range(1, 8)); i++)
        pkt.push_back(($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom));
      model_pkt(0, pkt);
      send_pkt(0, pkt, 1'b1);
    end
    wait_done(0, 60000);

    // Host bus reset with an incomplete packet buffered
    pkt = {}; pkt.push_back(8'h11); pkt.push_back(8'h22); pkt.push_back(8'h33);
    send_pkt(0, pkt, 1'b0);
    base = brst_cnt;
    host_se0 = 1'b1;
    repeat (15 * DIV_FS) @(negedge clk);
    check("brst_early", brst_cnt - base, 0);
    repeat (DIV_FS) @(negedge clk);
    check("brst_pulse", brst_cnt - base, 1);
    repeat (20 * DIV_FS) @(negedge clk);
    check("brst_single", brst_cnt - base, 1);
    host_se0 = 1'b0;
    repeat (2 * DIV_FS) @(negedge clk);
    pkt = {}; pkt.push_back(8'h3C);
    model_pkt(0, pkt); send_pkt(0, pkt, 1'b1); wait_done(0, 5000);

    // vbus loss during the second byte of a three-byte packet
    mon_off0 = 1'b1;
    pkt = {}; pkt.push_back(8'h00); pkt.push_back(8'h81); pkt.push_back(8'h42);
    send_pkt(0, pkt, 1'b1);
    t = 0;
    while (!fs_busy && t < 200) begin @(negedge clk); t++; end
    check("abort_tx_start", int'(t < 200), 1);
    repeat (20 * DIV_FS) @(negedge clk);
    vbus_fs = 1'b0;
    @(negedge clk);
    check("abort_state", int'(fs_state), 0);
    check("abort_se0", sym(0), S_SE0);
    check("abort_busy_ready", int'({fs_busy, fs_if.in_ready}), 0);
    check("abort_pulls", int'({fs_pdp, fs_pdm}), 0);
    ok = 1;
    repeat (3 * DIV_FS) begin
      @(negedge clk);
      if (sym(0) != S_SE0 || fs_busy || fs_state != 3'd0) ok = 0;
    end
    check("abort_no_eop", ok, 1);
    vbus_fs = 1'b1;
    t = 0;
    while (fs_state != 3'd2 && t < 2000) begin @(negedge clk); t++; end
    check("reattach_idle", int'(t < 2000), 1);
    mon_off0 = 1'b0;
    pkt = {}; pkt.push_back(8'h5A);
    model_pkt(0, pkt); send_pkt(0, pkt, 1'b1); wait_done(0, 5000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
